pe_array_3x3: RTL and testbench

Sequenced 3x3 processing-element array that performs an 8-bit unsigned 2D convolution (valid mode, stride 1) of a 5x5 input feature map with a 3x3 filter, producing a 3x3 output map. It is the compute core of the accelerator datapath. It takes flat parallel ifmap and filter buses from the buffer stage and presents a flat registered result bus to the output stage. Row-stationary mapping: PE(i,j) holds filter row i and streams ifmap row i+j; the three PEs in column j are summed to form output row j.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_array_3x3_pe.sv | 35 +++
 rtl/pe_array_3x3.sv | 107 ++++++++++
 tb/tb_pe_array_3x3.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared sizing, element types and flat-bus slice helpers for the 3x3
// row-stationary convolution array.
package pe_pkg;
  localparam int DATA_W     = 8;
  localparam int IFMAP_DIM  = 5;
  localparam int FILTER_DIM = 3;
  localparam int OUT_DIM    = 3;

  localparam int IFMAP_BUS_W  = IFMAP_DIM * IFMAP_DIM * DATA_W;
  localparam int FILTER_BUS_W = FILTER_DIM * FILTER_DIM * DATA_W;
  localparam int OUT_BUS_W    = OUT_DIM * OUT_DIM * DATA_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        cnt_t;

  function automatic int ifmap_lsb(input int r, input int c);
    return (r * IFMAP_DIM + c) * DATA_W;
  endfunction

  function automatic int filter_lsb(input int i, input int k);
    return (i * FILTER_DIM + k) * DATA_W;
  endfunction

  function automatic int out_lsb(input int y, input int x);
    return (y * OUT_DIM + x) * DATA_W;
  endfunction
endpackage

// File: rtl/pe_array_3x3_pe.sv
// Single processing element: 8-bit wrapping multiply-accumulate with a
// synchronous clear that wins over the running sum.
module pe
  import pe_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  clr_i,
  input  data_t wgt_i,
  input  data_t act_i,
  output data_t result_o
);

  data_t acc_q;
  data_t acc_d;
  data_t prod;

  // Product is truncated before the add so both wrap at 8 bits.
  assign prod     = data_t'(wgt_i * act_i);
  assign result_o = acc_q + prod;

  always_comb begin
    acc_d = clr_i ? '0 : result_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pe_array_3x3.sv
// 3x3 row-stationary PE array: a k/x sequencer steers filter taps and ifmap
// windows into nine PEs; column sums land in the output map one column per pass.
module pe_array_3x3
  import pe_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [IFMAP_BUS_W-1:0]  ifmap_in_flat,
  input  logic [FILTER_BUS_W-1:0] filter_in_flat,
  output logic [OUT_BUS_W-1:0]    sum_out_flat
);

  cnt_t  k_q, k_d;
  cnt_t  x_q, x_d;
  logic  last_tap;
  data_t wgt     [FILTER_DIM][OUT_DIM];
  data_t act     [FILTER_DIM][OUT_DIM];
  data_t res     [FILTER_DIM][OUT_DIM];
  data_t col_sum [OUT_DIM];
  data_t sum_q   [OUT_DIM*OUT_DIM];
  data_t sum_d   [OUT_DIM*OUT_DIM];

  assign last_tap = (k_q == 2'd2);

  always_comb begin
    k_d = last_tap ? 2'd0 : k_q + 2'd1;
    x_d = x_q;
    if (last_tap) begin
      x_d = (x_q == 2'd2) ? 2'd0 : x_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= '0;
      x_q <= '0;
    end else if (en) begin
      k_q <= k_d;
      x_q <= x_d;
    end
  end

  // PE(i,j) sees filter row i tap k and ifmap row i+j at column x+k.
  always_comb begin
    for (int i = 0; i < FILTER_DIM; i++) begin
      for (int j = 0; j < OUT_DIM; j++) begin
        wgt[i][j] = filter_in_flat[filter_lsb(i, int'(k_q)) +: DATA_W];
        act[i][j] = ifmap_in_flat[ifmap_lsb(i + j, int'(x_q) + int'(k_q)) +: DATA_W];
      end
    end
  end

  for (genvar gi = 0; gi < FILTER_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_col
      pe u_pe (
        .clk_i    (clk),
        .rst_ni   (rst),
        .en_i     (en),
        .clr_i    (last_tap),
        .wgt_i    (wgt[gi][gj]),
        .act_i    (act[gi][gj]),
        .result_o (res[gi][gj])
      );
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_DIM; j++) begin
      col_sum[j] = '0;
      for (int i = 0; i < FILTER_DIM; i++) begin
        col_sum[j] = col_sum[j] + res[i][j];
      end
    end
  end

  // Only the current output column is rewritten on the last tap.
  always_comb begin
    sum_d = sum_q;
    if (last_tap) begin
      for (int y = 0; y < OUT_DIM; y++) begin
        for (int x = 0; x < OUT_DIM; x++) begin
          if (int'(x_q) == x) begin
            sum_d[y*OUT_DIM + x] = col_sum[y];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < OUT_DIM*OUT_DIM; n++) begin
        sum_q[n] <= '0;
      end
    end else if (en) begin
      sum_q <= sum_d;
    end
  end

  for (genvar gy = 0; gy < OUT_DIM; gy++) begin : g_out_y
    for (genvar gx = 0; gx < OUT_DIM; gx++) begin : g_out_x
      assign sum_out_flat[(gy*OUT_DIM + gx)*DATA_W +: DATA_W] = sum_q[gy*OUT_DIM + gx];
    end
  end

endmodule

// File: tb/tb_pe_array_3x3.sv
// Scoreboard bench for pe_array_3x3: stimulus queues expected maps tagged with
// the enabled-edge count at which they must be visible; a monitor pops them.
module tb_pe_array_3x3;
  localparam int W = 72;

  logic           clk;
  logic           rst;
  logic           en;
  logic [199:0]   ifmap_in_flat;
  logic [71:0]    filter_in_flat;
  logic [W-1:0]   sum_out_flat;

  logic [W-1:0]   exp_q[$];
  int             due_q[$];
  int             edge_cnt = 0;
  int             total = 0;
  int             bad = 0;

  pe_array_3x3 dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .ifmap_in_flat  (ifmap_in_flat),
    .filter_in_flat (filter_in_flat),
    .sum_out_flat   (sum_out_flat)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled edges since the last reset release; the monitor's notion of time.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else if (en) edge_cnt <= edge_cnt + 1;
  end

  // Monitor: compare the output map on the falling edge once its due edge is reached.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    int           due_v;
    if (exp_q.size() > 0 && due_q[0] == edge_cnt) begin
      exp_v = exp_q.pop_front();
      due_v = due_q.pop_front();
      total = total + 1;
      if (sum_out_flat !== exp_v) begin
        bad = bad + 1;
        $display("FAIL map@edge%0d got=%h exp=%h", due_v, sum_out_flat, exp_v);
      end
    end
  end

  // Hand-derived ramp result: out(y,x) = 25 + 63*(5y+x) mod 256
  // (0x19,0x58,0x97 / 0x54,... / ...,0x0D); columns >= cols still zero.
  function automatic logic [W-1:0] ramp_map(input int cols);
    logic [W-1:0] m;
    m = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < cols; x++)
        m[(3*y + x)*8 +: 8] = 8'((25 + 63*(5*y + x)) % 256);
    return m;
  endfunction

  // Identity filter picks ifmap(y+1,x+1) = 5y+x+7.
  function automatic logic [W-1:0] ident_map();
    logic [W-1:0] m;
    m = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        m[(3*y + x)*8 +: 8] = 8'(5*y + x + 7);
    return m;
  endfunction

  // Driver tasks
  task automatic push(input int due, input logic [W-1:0] v);
    due_q.push_back(due);
    exp_q.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_ramp();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        ifmap_in_flat[(5*r + c)*8 +: 8] = 8'(5*r + c + 1);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        filter_in_flat[(3*i + k)*8 +: 8] = 8'(3*i + k + 3);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en  = 1'($urandom_range(0, 1));
    for (int b = 0; b < 25; b++) ifmap_in_flat[b*8 +: 8] = 8'($urandom_range(0, 255));
    for (int b = 0; b < 9; b++) filter_in_flat[b*8 +: 8] = 8'($urandom_range(0, 255));
    push(0, '0);
    step(3);
    en  = 1'b0;
    rst = 1'b1;
    step(1);
  endtask

  // Stimulus
  initial begin
    rst = 1'b0;
    en = 1'b0;
    ifmap_in_flat = '0;
    filter_in_flat = '0;

    // Ramp: partial columns, full map, then stability over a second pass.
    apply_reset();
    set_ramp();
    en = 1'b1;
    push(3, ramp_map(1));
    push(6, ramp_map(2));
    push(9, ramp_map(3));
    push(12, ramp_map(3));
    push(15, ramp_map(3));
    push(18, ramp_map(3));
    step(18);
    total = total + 1;
    if (sum_out_flat !== ramp_map(3)) begin
      bad = bad + 1;
      $display("FAIL ramp stable got=%h exp=%h", sum_out_flat, ramp_map(3));
    end

    // Reset mid-pass with en still high: immediate clear, then a clean pass.
    step(4);
    rst = 1'b0;
    #1;
    total = total + 1;
    if (sum_out_flat !== '0) begin
      bad = bad + 1;
      $display("FAIL async reset clear got=%h exp=0", sum_out_flat);
    end
    push(0, '0);
    step(2);
    rst = 1'b1;
    push(3, ramp_map(1));
    push(6, ramp_map(2));
    push(9, ramp_map(3));
    step(10);

    // Identity filter.
    apply_reset();
    set_ramp();
    filter_in_flat = '0;
    filter_in_flat[(3*1 + 1)*8 +: 8] = 8'd1;
    en = 1'b1;
    push(9, ident_map());
    step(10);

    // Overflow: 255*255 wraps to 1, nine taps give 9.
    apply_reset();
    ifmap_in_flat  = {200{1'b1}};
    filter_in_flat = {72{1'b1}};
    en = 1'b1;
    push(9, {9{8'h09}});
    step(10);

    // Enable hold: freeze for 5 cycles after enabled edge 4.
    apply_reset();
    set_ramp();
    en = 1'b1;
    push(3, ramp_map(1));
    push(4, ramp_map(1));
    push(6, ramp_map(2));
    push(9, ramp_map(3));
    step(4);
    en = 1'b0;
    step(5);
    total = total + 1;
    if (sum_out_flat !== ramp_map(1)) begin
      bad = bad + 1;
      $display("FAIL enable hold got=%h exp=%h", sum_out_flat, ramp_map(1));
    end
    en = 1'b1;
    step(6);

    // Final report
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    while (exp_q.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL map@edge%0d got=never_checked exp=%h", due_q[0], exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
